// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the packed ALU command driver.
package alu_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } drv_state_t;

  // Field layout of the packed command / ALU input byte.
  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 5;
  localparam int A_MSB   = 4;
  localparam int A_LSB   = 2;
  localparam int B_MSB   = 1;
  localparam int B_LSB   = 0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_drv_fifo.sv
// Synchronous power-of-two FIFO with registered fill level; push is refused when full
// even if a pop happens in the same cycle.
module alu_drv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and fill-level bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues host command bytes, drives each onto the packed ALU input, waits the settle time,
// and returns the captured result. Define ALU_DRV_OPCNT_EN to add the op_count output.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  alu_in,
  input  logic [7:0]  alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_cmd,
  output logic [7:0]  rsp_result,
  output logic        busy
`ifdef ALU_DRV_OPCNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drv_state_t       state_r;
  drv_state_t       next_state_s;
  logic [CNT_W-1:0] settle_cnt_r;
  logic [7:0]       alu_in_r;
  logic [7:0]       rsp_cmd_r;
  logic [7:0]       rsp_result_r;
  logic [7:0]       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_pop_s;
  logic [CW-1:0]    fifo_count_s;

  alu_drv_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (fifo_pop_s),
    .wdata (cmd_data),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) next_state_s = ST_SETTLE;
        else               next_state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_r == CNT_W'(1)) next_state_s = ST_RESP;
        else                           next_state_s = ST_SETTLE;
      end
      ST_RESP: begin
        if (rsp_ready) next_state_s = ST_IDLE;
        else           next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Control outputs decoded from registered state and fill level.
  always_comb begin
    fifo_pop_s = 1'b0;
    rsp_valid  = 1'b0;
    cmd_ready  = !fifo_full_s;
    busy       = (state_r != ST_IDLE) || (|fifo_count_s);
    case (state_r)
      ST_IDLE: fifo_pop_s = !fifo_empty_s;
      ST_RESP: rsp_valid  = 1'b1;
      default: fifo_pop_s = 1'b0;
    endcase
  end

  // Datapath: load on pop, count down the settle window, capture on its last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_r     <= 8'h00;
      rsp_cmd_r    <= 8'h00;
      rsp_result_r <= 8'h00;
      settle_cnt_r <= CNT_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            alu_in_r     <= {fifo_head_s[SEL_MSB:SEL_LSB], fifo_head_s[A_MSB:A_LSB],
                             fifo_head_s[B_MSB:B_LSB]};
            rsp_cmd_r    <= fifo_head_s;
            settle_cnt_r <= CNT_W'(SETTLE_CYCLES);
          end
        end
        ST_SETTLE: begin
          settle_cnt_r <= settle_cnt_r - CNT_W'(1);
          if (settle_cnt_r == CNT_W'(1)) rsp_result_r <= alu_result;
        end
        default: settle_cnt_r <= settle_cnt_r;
      endcase
    end
  end

  assign alu_in     = alu_in_r;
  assign rsp_cmd    = rsp_cmd_r;
  assign rsp_result = rsp_result_r;

`ifdef ALU_DRV_OPCNT_EN
  logic [15:0] op_count_r;

  // Completed-handshake counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                          op_count_r <= 16'h0000;
    else if (rsp_valid && rsp_ready)  op_count_r <= op_count_r + 16'h0001;
    else                              op_count_r <= op_count_r;
  end

  assign op_count = op_count_r;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (default 2/4 and 1/2 settle/depth) checked each
// cycle against a timestamp-based transaction model, plus hand-computed response tables.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid   [2];
  logic [7:0] cmd_data    [2];
  logic       rsp_ready   [2];
  logic       cmd_ready_w [2];
  logic [7:0] alu_in_w    [2];
  logic [7:0] alu_res_w   [2];
  logic       rsp_valid_w [2];
  logic [7:0] rsp_cmd_w   [2];
  logic [7:0] rsp_res_w   [2];
  logic       busy_w      [2];
`ifdef ALU_DRV_OPCNT_EN
  logic [15:0] op_w [2];
`endif

  // Stub ALU
  assign alu_res_w[0] = alu_in_w[0] ^ 8'hA5;
  assign alu_res_w[1] = alu_in_w[1] ^ 8'hA5;

  alu_cmd_driver #(.SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_data(cmd_data[0]), .alu_in(alu_in_w[0]), .alu_result(alu_res_w[0]),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]), .rsp_cmd(rsp_cmd_w[0]),
    .rsp_result(rsp_res_w[0]), .busy(busy_w[0])
`ifdef ALU_DRV_OPCNT_EN
    , .op_count(op_w[0])
`endif
  );

  alu_cmd_driver #(.SETTLE_CYCLES(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_data(cmd_data[1]), .alu_in(alu_in_w[1]), .alu_result(alu_res_w[1]),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]), .rsp_cmd(rsp_cmd_w[1]),
    .rsp_result(rsp_res_w[1]), .busy(busy_w[1])
`ifdef ALU_DRV_OPCNT_EN
    , .op_count(op_w[1])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit model_on = 1'b0;

  // Model: queue contents, current job with its pop timestamp, last captured result.
  int          s_p [2] = '{2, 1};
  int          d_p [2] = '{4, 2};
  logic [7:0]  mq    [2][16];
  int          mh    [2];
  int          mc    [2];
  bit          job   [2];
  int          pop_t [2];
  logic [7:0]  m_cmd [2];
  logic [7:0]  m_res [2];
  logic [15:0] m_op  [2];

  logic [7:0] lg_cmd [2][64];
  logic [7:0] lg_res [2][64];
  int         lg_cyc [2][64];
  int         lg_n   [2];
  int         acc_cyc[2];

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask

  function automatic bit exp_rv(input int i);
    return job[i] && (cyc >= pop_t[i] + s_p[i] + 1);
  endfunction

  task automatic model_step();
    bit was_job;
    bit hs;
    int qc;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mh[i] = 0; mc[i] = 0; job[i] = 1'b0; pop_t[i] = 0;
        m_cmd[i] = 8'h00; m_res[i] = 8'h00; m_op[i] = 16'h0000;
      end else begin
        was_job = job[i];
        qc      = mc[i];
        hs      = exp_rv(i) && rsp_ready[i];
        if (job[i] && cyc == pop_t[i] + s_p[i]) m_res[i] = m_cmd[i] ^ 8'hA5;
        if (hs) begin
          job[i]  = 1'b0;
          m_op[i] = m_op[i] + 16'h0001;
        end
        if (!was_job && qc > 0) begin
          m_cmd[i] = mq[i][mh[i]];
          mh[i]    = (mh[i] + 1) % 16;
          mc[i]    = mc[i] - 1;
          job[i]   = 1'b1;
          pop_t[i] = cyc;
        end
        if (cmd_valid[i] && qc < d_p[i]) begin
          mq[i][(mh[i] + mc[i]) % 16] = cmd_data[i];
          mc[i] = mc[i] + 1;
        end
      end
    end
    if (rst) model_on = 1'b1;
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, and handshake logging.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        check("cmd_ready", i, cmd_ready_w[i], mc[i] < d_p[i]);
        check("rsp_valid", i, rsp_valid_w[i], exp_rv(i));
        check("busy", i, busy_w[i], job[i] || mc[i] > 0);
        check("alu_in", i, alu_in_w[i], m_cmd[i]);
        check("rsp_cmd", i, rsp_cmd_w[i], m_cmd[i]);
        check("rsp_result", i, rsp_res_w[i], m_res[i]);
`ifdef ALU_DRV_OPCNT_EN
        check("op_count", i, op_w[i], m_op[i]);
`endif
        if (rsp_valid_w[i] && rsp_ready[i] && lg_n[i] < 64) begin
          lg_cmd[i][lg_n[i]] = rsp_cmd_w[i];
          lg_res[i][lg_n[i]] = rsp_res_w[i];
          lg_cyc[i][lg_n[i]] = cyc;
          lg_n[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid[i] = 1'b1;
    cmd_data[i]  = d;
    while (!cmd_ready_w[i] && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("push_timeout", i, 32'd1, 32'd0);
    else          acc_cyc[i] = cyc;
    tick();
    cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_rv(input int i);
    int n;
    n = 0;
    while (!rsp_valid_w[i] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rsp_timeout", i, 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy_w[i] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", i, 32'd1, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 0, cmd_ready_w[0], 32'd1);
    check({tag, "_alu_in"}, 0, alu_in_w[0], 32'h00);
    check({tag, "_rsp_valid"}, 0, rsp_valid_w[0], 32'd0);
    check({tag, "_rsp_cmd"}, 0, rsp_cmd_w[0], 32'h00);
    check({tag, "_rsp_result"}, 0, rsp_res_w[0], 32'h00);
    check({tag, "_busy"}, 0, busy_w[0], 32'd0);
  endtask

  logic [7:0] t2_res [6] = '{8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3};
  logic [7:0] t5_res [3] = '{8'hE4, 8'hE7, 8'hE6};
  logic [7:0] t6_res [8] = '{8'h25, 8'h24, 8'h27, 8'h26, 8'h21, 8'h20, 8'h23, 8'h22};

  initial begin
    int base;
    int t0;
    logic [7:0] h_cmd;
    logic [7:0] h_res;
    logic [7:0] h_alu;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_data[i] = 8'h00; rsp_ready[i] = 1'b1; lg_n[i] = 0;
      acc_cyc[i] = 0;
    end
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single command latency and values.
    push(0, 8'h3D);
    t0 = acc_cyc[0];
    wait_rv(0);
    check("t1_latency", 0, cyc, t0 + 4);
    check("t1_rsp_cmd", 0, rsp_cmd_w[0], 32'h3D);
    check("t1_rsp_result", 0, rsp_res_w[0], 32'h98);
    check("t1_alu_in", 0, alu_in_w[0], 32'h3D);
    tick();
    wait_idle(0);

    // Fill the queue with the response channel blocked.
    base = lg_n[0];
    rsp_ready[0] = 1'b0;
    for (int k = 1; k <= 5; k++) push(0, 8'(k));
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = 8'h06;
    repeat (5) tick();
    check("t2_full_not_ready", 0, cmd_ready_w[0], 32'd0);
    check("t2_no_rsp_yet", 0, lg_n[0], base);
    rsp_ready[0] = 1'b1;
    push(0, 8'h06);
    wait_idle(0);
    check("t2_rsp_count", 0, lg_n[0] - base, 32'd6);
    for (int k = 0; k < 6; k++) check("t2_rsp_order", 0, lg_res[0][base + k], t2_res[k]);

    // Long stall in RESP.
    rsp_ready[0] = 1'b0;
    push(0, 8'h5A);
    wait_rv(0);
    h_cmd = rsp_cmd_w[0]; h_res = rsp_res_w[0]; h_alu = alu_in_w[0];
    check("t3_rsp_result", 0, h_res, 32'hFF);
    repeat (10) tick();
    check("t3_hold_cmd", 0, rsp_cmd_w[0], h_cmd);
    check("t3_hold_res", 0, rsp_res_w[0], h_res);
    check("t3_hold_alu", 0, alu_in_w[0], h_alu);
    base = lg_n[0];
    rsp_ready[0] = 1'b1;
    repeat (4) tick();
    check("t3_single_hs", 0, lg_n[0] - base, 32'd1);

    // Reset during SETTLE with two entries queued.
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    check("t4_settling", 0, rsp_valid_w[0], 32'd0);
    check("t4_alu_in", 0, alu_in_w[0], 32'h11);
    rst = 1'b1;
    tick();
    check_reset_vals("t4");
    rst = 1'b0;
    base = lg_n[0];
    repeat (20) tick();
    check("t4_no_rsp", 0, lg_n[0], base);

    // Post-reset operation and handshake counter.
    base = lg_n[0];
    push(0, 8'h41);
    push(0, 8'h42);
    push(0, 8'h43);
    wait_idle(0);
    check("t5_rsp_count", 0, lg_n[0] - base, 32'd3);
    for (int k = 0; k < 3; k++) check("t5_rsp_order", 0, lg_res[0][base + k], t5_res[k]);
`ifdef ALU_DRV_OPCNT_EN
    check("t5_op_count", 0, op_w[0], 32'd3);
    force dut0.op_count_r = 16'hFFFF;
    m_op[0] = 16'hFFFF;
    #1;
    release dut0.op_count_r;
    push(0, 8'h44);
    wait_idle(0);
    check("t5_op_wrap", 0, op_w[0], 32'd0);
`endif

    // Streaming through the shallow, fast instance.
    base = lg_n[1];
    for (int k = 0; k < 8; k++) push(1, 8'h80 + 8'(k));
    wait_idle(1);
    check("t6_rsp_count", 1, lg_n[1] - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("t6_rsp_cmd", 1, lg_cmd[1][base + k], 8'h80 + 8'(k));
      check("t6_rsp_res", 1, lg_res[1][base + k], t6_res[k]);
      if (k > 0) check("t6_spacing", 1, lg_cyc[1][base + k] - lg_cyc[1][base + k - 1], 32'd3);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
